// File: rtl/alu_regbank_unit_if.sv
// Bundles the register-bank and ALU signals of alu_regbank_unit.
// The master drives addresses, write data and ALU operands; the slave returns reads and results.
interface alu_regbank_unit_if;
  logic [4:0]  adrsReadA;
  logic [4:0]  adrsReadB;
  logic [4:0]  adrsWrite;
  logic        RegEn;
  logic [31:0] write;
  logic        jal;
  logic [31:0] readA;
  logic [31:0] readB;
  logic [5:0]  funct;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_r;
  logic        alu_zero;

  modport master (
    output adrsReadA, adrsReadB, adrsWrite, RegEn, write, jal, funct, alu_op, alu_a, alu_b,
    input  readA, readB, alu_sel, alu_r, alu_zero
  );

  modport slave (
    input  adrsReadA, adrsReadB, adrsWrite, RegEn, write, jal, funct, alu_op, alu_a, alu_b,
    output readA, readB, alu_sel, alu_r, alu_zero
  );
endinterface

// File: rtl/alu_regbank_unit.sv
// MIPS datapath core: 32x32 register bank with write-through bypass and JAL link redirect,
// ALU-control decoder and 32-bit combinational ALU.
module alu_regbank_unit (
  input logic               clk,
  input logic               reset,
  alu_regbank_unit_if.slave bus
);

  localparam logic [2:0] SelAnd  = 3'b000;
  localparam logic [2:0] SelOr   = 3'b001;
  localparam logic [2:0] SelAdd  = 3'b010;
  localparam logic [2:0] SelXor  = 3'b011;
  localparam logic [2:0] SelNor  = 3'b100;
  localparam logic [2:0] SelSltu = 3'b101;
  localparam logic [2:0] SelSub  = 3'b110;
  localparam logic [2:0] SelSlt  = 3'b111;

  logic [31:0] regs_q [32];
  logic [4:0]  wr_addr;
  logic        wr_en;
  logic [2:0]  alu_sel;
  logic [31:0] alu_r;

  // JAL links into r31; writes to r0 are dropped here so the bypass ignores them too.
  assign wr_addr = bus.jal ? 5'd31 : bus.adrsWrite;
  assign wr_en   = bus.RegEn && (wr_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= bus.write;
    end
  end

  // Reads are forced to zero while reset is asserted.
  always_comb begin
    bus.readA = '0;
    bus.readB = '0;
    if (reset) begin
      if (wr_en && (wr_addr == bus.adrsReadA)) begin
        bus.readA = bus.write;
      end else if (bus.adrsReadA != 5'd0) begin
        bus.readA = regs_q[bus.adrsReadA];
      end
      if (wr_en && (wr_addr == bus.adrsReadB)) begin
        bus.readB = bus.write;
      end else if (bus.adrsReadB != 5'd0) begin
        bus.readB = regs_q[bus.adrsReadB];
      end
    end
  end

  always_comb begin
    alu_sel = SelAdd;
    unique case (bus.alu_op)
      3'b000: alu_sel = SelAdd;
      3'b001: alu_sel = SelSub;
      3'b010: begin
        case (bus.funct)
          6'b100000, 6'b100001: alu_sel = SelAdd;
          6'b100010, 6'b100011: alu_sel = SelSub;
          6'b100100:            alu_sel = SelAnd;
          6'b100101:            alu_sel = SelOr;
          6'b100110:            alu_sel = SelXor;
          6'b100111:            alu_sel = SelNor;
          6'b101010:            alu_sel = SelSlt;
          6'b101011:            alu_sel = SelSltu;
          default:              alu_sel = SelAdd;
        endcase
      end
      3'b011: alu_sel = SelAnd;
      3'b100: alu_sel = SelOr;
      3'b101: alu_sel = SelSlt;
      3'b110: alu_sel = SelXor;
      3'b111: alu_sel = SelSltu;
    endcase
  end

  always_comb begin
    alu_r = '0;
    unique case (alu_sel)
      SelAnd:  alu_r = bus.alu_a & bus.alu_b;
      SelOr:   alu_r = bus.alu_a | bus.alu_b;
      SelAdd:  alu_r = bus.alu_a + bus.alu_b;
      SelXor:  alu_r = bus.alu_a ^ bus.alu_b;
      SelNor:  alu_r = ~(bus.alu_a | bus.alu_b);
      SelSltu: alu_r = {31'b0, bus.alu_a < bus.alu_b};
      SelSub:  alu_r = bus.alu_a - bus.alu_b;
      SelSlt:  alu_r = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
    endcase
  end

  assign bus.alu_sel  = alu_sel;
  assign bus.alu_r    = alu_r;
  assign bus.alu_zero = (alu_r == 32'h0);

endmodule

// File: tb/tb_alu_regbank_unit.sv
// Directed and randomized checks of alu_regbank_unit against a behavioural register/ALU model.
module tb_alu_regbank_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_regbank_unit_if bus_if ();

  alu_regbank_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] model [32];

  typedef enum {OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSlt, OpSltu} op_e;

  function automatic op_e ref_op(logic [2:0] op, logic [5:0] f);
    case (op)
      3'd0: return OpAdd;
      3'd1: return OpSub;
      3'd3: return OpAnd;
      3'd4: return OpOr;
      3'd5: return OpSlt;
      3'd6: return OpXor;
      3'd7: return OpSltu;
      default: begin
        case (f)
          6'h20, 6'h21: return OpAdd;
          6'h22, 6'h23: return OpSub;
          6'h24: return OpAnd;
          6'h25: return OpOr;
          6'h26: return OpXor;
          6'h27: return OpNor;
          6'h2a: return OpSlt;
          6'h2b: return OpSltu;
          default: return OpAdd;
        endcase
      end
    endcase
  endfunction

  function automatic logic [2:0] ref_sel(op_e k);
    case (k)
      OpAnd:  return 3'b000;
      OpOr:   return 3'b001;
      OpAdd:  return 3'b010;
      OpXor:  return 3'b011;
      OpNor:  return 3'b100;
      OpSltu: return 3'b101;
      OpSub:  return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(op_e k, logic [31:0] a, logic [31:0] b);
    case (k)
      OpAdd:  return a + b;
      OpSub:  return a - b;
      OpAnd:  return a & b;
      OpOr:   return a | b;
      OpXor:  return a ^ b;
      OpNor:  return ~(a | b);
      OpSlt:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(logic [4:0] ra);
    logic [4:0] weff;
    if (!reset) return 32'h0;
    weff = bus_if.jal ? 5'd31 : bus_if.adrsWrite;
    if (bus_if.RegEn && weff != 5'd0 && weff == ra) return bus_if.write;
    return (ra == 5'd0) ? 32'h0 : model[ra];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Applies the current inputs at the next rising edge and mirrors the effect in the model.
  task automatic tick();
    logic [4:0] weff;
    weff = bus_if.jal ? 5'd31 : bus_if.adrsWrite;
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (bus_if.RegEn && weff != 5'd0) begin
      model[weff] = bus_if.write;
    end
    #2;
  endtask

  task automatic set_reg(logic en, logic j, logic [4:0] wa, logic [31:0] wd,
                         logic [4:0] ra, logic [4:0] rb);
    bus_if.RegEn     = en;
    bus_if.jal       = j;
    bus_if.adrsWrite = wa;
    bus_if.write     = wd;
    bus_if.adrsReadA = ra;
    bus_if.adrsReadB = rb;
  endtask

  task automatic chk_reads(string tag);
    #1;
    chk({tag, "_A"}, bus_if.readA, exp_read(bus_if.adrsReadA));
    chk({tag, "_B"}, bus_if.readB, exp_read(bus_if.adrsReadB));
  endtask

  task automatic chk_alu(string tag, logic [2:0] op, logic [5:0] f, logic [31:0] a,
                         logic [31:0] b);
    op_e k;
    logic [31:0] r;
    bus_if.alu_op = op;
    bus_if.funct  = f;
    bus_if.alu_a  = a;
    bus_if.alu_b  = b;
    #1;
    k = ref_op(op, f);
    r = ref_alu(k, a, b);
    chk({tag, "_sel"}, {29'b0, bus_if.alu_sel}, {29'b0, ref_sel(k)});
    chk({tag, "_r"}, bus_if.alu_r, r);
    chk({tag, "_zero"}, {31'b0, bus_if.alu_zero}, {31'b0, r == 32'h0});
  endtask

  initial begin
    logic [5:0]  fn_tab  [7];
    logic [2:0]  sel_tab [7];
    logic [2:0]  op_tab  [7];
    logic [2:0]  osel_tab[7];
    logic [5:0]  valid_f [10];
    logic [31:0] a, b;

    fn_tab   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b111111};
    sel_tab  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b010};
    op_tab   = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    osel_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b101};
    valid_f  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

    reset = 1'b0;
    bus_if.funct = '0; bus_if.alu_op = '0; bus_if.alu_a = '0; bus_if.alu_b = '0;
    set_reg(1'b1, 1'b0, 5'd9, 32'hAAAA_5555, 5'd9, 5'd9);
    #1;
    chk("reset_bypass_A", bus_if.readA, 32'h0);
    chk("reset_bypass_B", bus_if.readB, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    set_reg(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    for (int i = 0; i < 32; i++) begin
      bus_if.adrsReadA = 5'(i);
      bus_if.adrsReadB = 5'(31 - i);
      #1;
      chk($sformatf("post_reset_A%0d", i), bus_if.readA, 32'h0);
      chk($sformatf("post_reset_B%0d", 31 - i), bus_if.readB, 32'h0);
      tick();
    end

    set_reg(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6);
    #1;
    chk("bypass_r5", bus_if.readA, 32'hDEAD_BEEF);
    chk("bypass_r6_untouched", bus_if.readB, 32'h0);
    tick();
    bus_if.RegEn = 1'b0;
    #1;
    chk("stored_r5", bus_if.readA, 32'hDEAD_BEEF);

    set_reg(1'b1, 1'b0, 5'd0, 32'h0000_1234, 5'd0, 5'd5);
    #1;
    chk("r0_no_bypass", bus_if.readA, 32'h0);
    tick();
    bus_if.RegEn = 1'b0;
    #1;
    chk("r0_after_write", bus_if.readA, 32'h0);

    set_reg(1'b1, 1'b1, 5'd7, 32'h0040_0010, 5'd31, 5'd7);
    #1;
    chk("jal_bypass_r31", bus_if.readA, 32'h0040_0010);
    chk("jal_r7_bypass_off", bus_if.readB, 32'h0);
    tick();
    set_reg(1'b0, 1'b1, 5'd7, 32'hFFFF_FFFF, 5'd31, 5'd7);
    #1;
    chk("jal_no_en_r31", bus_if.readA, 32'h0040_0010);
    tick();
    bus_if.jal = 1'b0;
    #1;
    chk("jal_r31", bus_if.readA, 32'h0040_0010);
    chk("jal_r7_unchanged", bus_if.readB, 32'h0);

    for (int i = 0; i < 7; i++) begin
      bus_if.alu_op = 3'b010;
      bus_if.funct  = fn_tab[i];
      #1;
      chk($sformatf("rtype_sel_%b", fn_tab[i]), {29'b0, bus_if.alu_sel}, {29'b0, sel_tab[i]});
    end
    for (int i = 0; i < 7; i++) begin
      bus_if.alu_op = op_tab[i];
      bus_if.funct  = 6'h24;
      #1;
      chk($sformatf("op_sel_%b", op_tab[i]), {29'b0, bus_if.alu_sel}, {29'b0, osel_tab[i]});
    end

    chk_alu("add_wrap", 3'd0, 6'h0, 32'hFFFF_FFFF, 32'h1);
    chk("add_wrap_const", bus_if.alu_r, 32'h0);
    chk("add_wrap_zero", {31'b0, bus_if.alu_zero}, 32'h1);
    chk_alu("sub_neg", 3'd1, 6'h0, 32'd5, 32'd7);
    chk("sub_neg_const", bus_if.alu_r, 32'hFFFF_FFFE);
    chk_alu("slt_signed", 3'd5, 6'h0, 32'hFFFF_FFFF, 32'h1);
    chk("slt_signed_const", bus_if.alu_r, 32'h1);
    chk_alu("sltu_unsigned", 3'd7, 6'h0, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_unsigned_const", bus_if.alu_r, 32'h0);
    chk_alu("nor_zero", 3'd2, 6'h27, 32'h0, 32'h0);
    chk("nor_zero_const", bus_if.alu_r, 32'hFFFF_FFFF);

    for (int n = 0; n < 300; n++) begin
      set_reg(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
              5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) bus_if.adrsReadA = bus_if.adrsWrite;
      if ($urandom_range(0, 3) == 0) bus_if.adrsReadB = bus_if.jal ? 5'd31 : bus_if.adrsWrite;
      chk_reads($sformatf("rand_read%0d", n));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      chk_alu($sformatf("rand_alu%0d", n), 3'($urandom),
              ($urandom_range(0, 3) == 0) ? 6'($urandom) : valid_f[$urandom_range(0, 9)], a, b);
      tick();
    end

    for (int i = 1; i < 32; i++) begin
      set_reg(1'b1, 1'b0, 5'(i), 32'h1000_0000 | 32'(i), 5'd0, 5'd0);
      tick();
    end
    set_reg(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
    chk_reads("filled");
    reset = 1'b0;
    set_reg(1'b1, 1'b0, 5'd3, 32'h0000_0055, 5'd3, 5'd17);
    #1;
    chk("midreset_bypass_A", bus_if.readA, 32'h0);
    chk("midreset_read_B", bus_if.readB, 32'h0);
    tick();
    reset = 1'b1;
    bus_if.RegEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus_if.adrsReadA = 5'(i);
      bus_if.adrsReadB = 5'(i);
      #1;
      chk($sformatf("midreset_clear_A%0d", i), bus_if.readA, 32'h0);
      chk($sformatf("midreset_clear_B%0d", i), bus_if.readB, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
